// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared processor defaults for the decode hazard logic
//
// Purpose: default data/register-index widths and the "no bypass" data value.
// Ports: none (package).
package proc_pkg;

  localparam int DEFAULT_ARCH_BITS    = 32;
  localparam int DEFAULT_REG_IDX_BITS = 5;

  // Value driven on bypass data whenever no bypass hit is reported.
  localparam logic [DEFAULT_ARCH_BITS-1:0] BYPASS_NONE = '1;

endpackage

// File: rtl/hazard_src_lookup.sv
// rtl/hazard_src_lookup.sv - one-source producer priority scan plus pending test
//
// Purpose: resolve one source operand against the priority-ordered producer
// ports; fall back to the scoreboard pending flag when no producer matches.
// Ports:
//   prod_valid/prod_we [NUM_PROD]  producer entry valid / data final
//   prod_dst  [NUM_PROD*REG_IDX_BITS]  producer destinations, slice i = port i
//   prod_data [NUM_PROD*ARCH_BITS]     producer results
//   enable, idx                        operand check request and register
//   pending_nz                         scoreboard has in-flight writes to idx
//   block, hit, data                   stall, bypass valid, forwarded value
module hazard_src_lookup
  import proc_pkg::*;
#(
  parameter int ARCH_BITS    = DEFAULT_ARCH_BITS,
  parameter int REG_IDX_BITS = DEFAULT_REG_IDX_BITS,
  parameter int NUM_PROD     = 10
) (
  input  logic [NUM_PROD-1:0]              prod_valid,
  input  logic [NUM_PROD-1:0]              prod_we,
  input  logic [NUM_PROD*REG_IDX_BITS-1:0] prod_dst,
  input  logic [NUM_PROD*ARCH_BITS-1:0]    prod_data,
  input  logic                             enable,
  input  logic [REG_IDX_BITS-1:0]          idx,
  input  logic                             pending_nz,
  output logic                             block,
  output logic                             hit,
  output logic [ARCH_BITS-1:0]             data
);

  logic found;

  always_comb begin
    block = 1'b0;
    hit   = 1'b0;
    data  = {ARCH_BITS{1'b1}};
    found = 1'b0;
    if (enable) begin
      // Port 0 is the youngest producer, so the first match wins.
      for (int i = 0; i < NUM_PROD; i++) begin
        if (!found && prod_valid[i] && (prod_dst[i*REG_IDX_BITS +: REG_IDX_BITS] == idx)) begin
          found = 1'b1;
          if (prod_we[i]) begin
            hit  = 1'b1;
            data = prod_data[i*ARCH_BITS +: ARCH_BITS];
          end else begin
            block = 1'b1;
          end
        end
      end
      // Issued but not yet visible on any producer port.
      if (!found) block = pending_nz;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - operand hazard/bypass unit with in-flight scoreboard
//
// Purpose: per-cycle hazard resolution for NUM_SRC operands against NUM_PROD
// producer ports, a per-register in-flight write counter, and a stall counter.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   prodValid/prodWe/prodDst/prodData  producer ports (index 0 = youngest)
//   srcEnable/srcIdx             operands to check
//   issueValid/issueDst/issueReady     issue of a destination-writing instruction
//   retireValid/retireDst        register-file write completion
//   flush                        clear all in-flight state
//   block/hitBypass/bypassData   per-operand lookup result
//   stallCount                   saturating count of cycles with any block
//   sbError                      sticky: retire seen at zero count
module hazard_scoreboard
  import proc_pkg::*;
#(
  parameter int ARCH_BITS    = DEFAULT_ARCH_BITS,
  parameter int REG_IDX_BITS = DEFAULT_REG_IDX_BITS,
  parameter int NUM_PROD     = 10,
  parameter int NUM_SRC      = 2,
  parameter int CNT_BITS     = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PROD-1:0]              prodValid,
  input  logic [NUM_PROD-1:0]              prodWe,
  input  logic [NUM_PROD*REG_IDX_BITS-1:0] prodDst,
  input  logic [NUM_PROD*ARCH_BITS-1:0]    prodData,
  input  logic [NUM_SRC-1:0]               srcEnable,
  input  logic [NUM_SRC*REG_IDX_BITS-1:0]  srcIdx,
  input  logic                             issueValid,
  input  logic [REG_IDX_BITS-1:0]          issueDst,
  output logic                             issueReady,
  input  logic                             retireValid,
  input  logic [REG_IDX_BITS-1:0]          retireDst,
  input  logic                             flush,
  output logic [NUM_SRC-1:0]               block,
  output logic [NUM_SRC-1:0]               hitBypass,
  output logic [NUM_SRC*ARCH_BITS-1:0]     bypassData,
  output logic [31:0]                      stallCount,
  output logic                             sbError
);

  localparam int NREGS = 2**REG_IDX_BITS;
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

  logic [CNT_BITS-1:0] pending     [NREGS];
  logic [CNT_BITS-1:0] pending_nxt [NREGS];
  logic                issue_fire;
  logic                retire_at_zero;

  assign issueReady     = !rst && (pending[issueDst] != CNT_MAX);
  assign issue_fire     = issueValid && issueReady;
  assign retire_at_zero = retireValid && (pending[retireDst] == '0);

  // A zero-count retire is ignored, so an issue+retire to an idle register
  // still leaves one write in flight.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      pending_nxt[r] = pending[r];
      if (issue_fire && (issueDst == REG_IDX_BITS'(r)))
        pending_nxt[r] = pending_nxt[r] + CNT_ONE;
      if (retireValid && (retireDst == REG_IDX_BITS'(r)) && (pending[r] != '0))
        pending_nxt[r] = pending_nxt[r] - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) pending[r] <= '0;
      stallCount <= '0;
      sbError    <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++) pending[r] <= flush ? '0 : pending_nxt[r];
      if (!flush && retire_at_zero) sbError <= 1'b1;
      if ((|block) && (stallCount != '1)) stallCount <= stallCount + 32'd1;
    end
  end

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    logic [REG_IDX_BITS-1:0] idx;
    assign idx = srcIdx[s*REG_IDX_BITS +: REG_IDX_BITS];

    hazard_src_lookup #(
      .ARCH_BITS    (ARCH_BITS),
      .REG_IDX_BITS (REG_IDX_BITS),
      .NUM_PROD     (NUM_PROD)
    ) u_lookup (
      .prod_valid (prodValid),
      .prod_we    (prodWe),
      .prod_dst   (prodDst),
      .prod_data  (prodData),
      .enable     (srcEnable[s] & ~rst),
      .idx        (idx),
      .pending_nz (pending[idx] != '0),
      .block      (block[s]),
      .hit        (hitBypass[s]),
      .data       (bypassData[s*ARCH_BITS +: ARCH_BITS])
    );
  end

endmodule
